// File: rtl/fb_pkg.sv
// Shared framebuffer types and width helpers for the pixel packer/unstacker pair.
package fb_pkg;

   typedef logic [15:0]      pixel_t;
   typedef logic [7:0][15:0] chunk_t;
   typedef logic [7:0]       chunk_mask_t;

   function automatic int addr_w(input int hres, input int vres);
      return $clog2(hres * vres);
   endfunction

   function automatic int chunk_w(input int hres, input int vres);
      return $clog2((hres * vres) / 8);
   endfunction

endpackage

// File: rtl/pixel_prio_enc.sv
// Lowest-set-bit priority encoder over an 8-bit pixel enable mask.
module pixel_prio_enc (
   input  logic [7:0] bits_i,
   output logic [2:0] idx_o,
   output logic       any_o
);

   // Lowest index wins so pixels leave a chunk in ascending address order.
   always_comb begin
      any_o = |bits_i;
      casez (bits_i)
         8'b???????1: idx_o = 3'd0;
         8'b??????10: idx_o = 3'd1;
         8'b?????100: idx_o = 3'd2;
         8'b????1000: idx_o = 3'd3;
         8'b???10000: idx_o = 3'd4;
         8'b??100000: idx_o = 3'd5;
         8'b?1000000: idx_o = 3'd6;
         8'b10000000: idx_o = 3'd7;
         default:     idx_o = 3'd0;
      endcase
   end

endmodule

// File: rtl/pixel_unstacker.sv
// Splits 8-pixel framebuffer chunks into a one-pixel-per-cycle stream with
// full pixel addresses; an active plus a pending slot hides chunk turnover.
module pixel_unstacker
   import fb_pkg::*;
#(
   parameter  int HRES     = 1280,
   parameter  int VRES     = 720,
   localparam int ADDR_W   = addr_w(HRES, VRES),
   localparam int CHUNK_W  = chunk_w(HRES, VRES),
   localparam int LAST_PIX = HRES * VRES - 1
) (
   input  logic               clk_in,
   input  logic               rst_n_in,
   input  logic               chunk_valid_in,
   output logic               chunk_ready_out,
   input  logic [CHUNK_W-1:0] chunk_addr_in,
   input  chunk_t             chunk_data_in,
   input  chunk_mask_t        chunk_mask_in,
   input  logic               pixel_ready_in,
   output logic               pixel_valid_out,
   output logic [ADDR_W-1:0]  pixel_addr_out,
   output pixel_t             pixel_data_out,
   output logic               frame_last_out,
   output logic               busy_out
);

   logic               act_valid_q, act_valid_d;
   logic [CHUNK_W-1:0] act_addr_q, act_addr_d;
   chunk_t             act_data_q, act_data_d;
   chunk_mask_t        act_rem_q, act_rem_d;
   logic               pend_valid_q, pend_valid_d;
   logic [CHUNK_W-1:0] pend_addr_q, pend_addr_d;
   chunk_t             pend_data_q, pend_data_d;
   chunk_mask_t        pend_mask_q, pend_mask_d;

   logic [2:0]  idx_s;
   logic        any_s;
   logic        fire_s;
   logic        accept_s;
   logic        retire_s;
   chunk_mask_t rem_after_s;

   pixel_prio_enc u_prio_enc (
      .bits_i (act_rem_q),
      .idx_o  (idx_s),
      .any_o  (any_s)
   );

   // Ready is held low while reset is asserted, so it is gated by the reset pin.
   assign chunk_ready_out = rst_n_in && !pend_valid_q;
   assign accept_s        = chunk_valid_in && chunk_ready_out;
   assign pixel_valid_out = act_valid_q && any_s;
   assign fire_s          = pixel_valid_out && pixel_ready_in;
   assign rem_after_s     = fire_s ? (act_rem_q & ~(chunk_mask_t'(8'd1) << idx_s)) : act_rem_q;
   // A zero-mask chunk has nothing left from the start and retires right away.
   assign retire_s        = act_valid_q && (rem_after_s == chunk_mask_t'(8'd0));

   assign pixel_addr_out  = ADDR_W'({act_addr_q, idx_s});
   assign pixel_data_out  = act_data_q[idx_s];
   assign frame_last_out  = pixel_valid_out && (pixel_addr_out == ADDR_W'(LAST_PIX));
   assign busy_out        = act_valid_q || pend_valid_q;

   // Slot transfer: retire/refill priority, then pending capture, then direct load.
   always_comb begin
      act_valid_d  = act_valid_q;
      act_addr_d   = act_addr_q;
      act_data_d   = act_data_q;
      act_rem_d    = act_rem_q;
      pend_valid_d = pend_valid_q;
      pend_addr_d  = pend_addr_q;
      pend_data_d  = pend_data_q;
      pend_mask_d  = pend_mask_q;
      if (retire_s) begin
         if (pend_valid_q) begin
            act_valid_d  = 1'b1;
            act_addr_d   = pend_addr_q;
            act_data_d   = pend_data_q;
            act_rem_d    = pend_mask_q;
            pend_valid_d = accept_s;
            if (accept_s) begin
               pend_addr_d = chunk_addr_in;
               pend_data_d = chunk_data_in;
               pend_mask_d = chunk_mask_in;
            end else begin
               pend_mask_d = chunk_mask_t'(8'd0);
            end
         end else if (accept_s) begin
            act_valid_d = 1'b1;
            act_addr_d  = chunk_addr_in;
            act_data_d  = chunk_data_in;
            act_rem_d   = chunk_mask_in;
         end else begin
            act_valid_d = 1'b0;
            act_rem_d   = chunk_mask_t'(8'd0);
         end
      end else if (act_valid_q) begin
         act_rem_d = rem_after_s;
         if (accept_s) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = chunk_addr_in;
            pend_data_d  = chunk_data_in;
            pend_mask_d  = chunk_mask_in;
         end else begin
            pend_valid_d = pend_valid_q;
         end
      end else if (accept_s) begin
         act_valid_d = 1'b1;
         act_addr_d  = chunk_addr_in;
         act_data_d  = chunk_data_in;
         act_rem_d   = chunk_mask_in;
      end else begin
         act_valid_d = 1'b0;
      end
   end

   // Slot state registers; reset drops every buffered chunk.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         act_valid_q  <= 1'b0;
         act_addr_q   <= '0;
         act_data_q   <= '0;
         act_rem_q    <= '0;
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         pend_data_q  <= '0;
         pend_mask_q  <= '0;
      end else begin
         act_valid_q  <= act_valid_d;
         act_addr_q   <= act_addr_d;
         act_data_q   <= act_data_d;
         act_rem_q    <= act_rem_d;
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         pend_data_q  <= pend_data_d;
         pend_mask_q  <= pend_mask_d;
      end
   end

endmodule

// File: tb/tb_pixel_unstacker.sv
// Randomized and directed bench for pixel_unstacker against a pixel-queue model.
module tb_pixel_unstacker;
   import fb_pkg::*;

   localparam int ADDR_W   = 20;
   localparam int CHUNK_W  = 17;
   localparam int LAST_PIX = 1280 * 720 - 1;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [15:0]       data;
   } exp_t;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [15:0]       data;
      int                cyc;
   } fire_t;

   logic               clk_in = 1'b0;
   logic               rst_n_in;
   logic               chunk_valid_in;
   logic               chunk_ready_out;
   logic [CHUNK_W-1:0] chunk_addr_in;
   chunk_t             chunk_data_in;
   chunk_mask_t        chunk_mask_in;
   logic               pixel_ready_in = 1'b1;
   logic               pixel_valid_out;
   logic [ADDR_W-1:0]  pixel_addr_out;
   pixel_t             pixel_data_out;
   logic               frame_last_out;
   logic               busy_out;

   int    vecs = 0;
   int    errs = 0;
   int    cyc = 0;
   int    last_cnt = 0;
   bit    rand_rdy = 1'b0;
   exp_t  exp_q[$];
   fire_t fired_log[$];
   logic              prev_stall = 1'b0;
   logic [ADDR_W-1:0] prev_addr;
   logic [15:0]       prev_data;

   pixel_unstacker dut (
      .clk_in          (clk_in),
      .rst_n_in        (rst_n_in),
      .chunk_valid_in  (chunk_valid_in),
      .chunk_ready_out (chunk_ready_out),
      .chunk_addr_in   (chunk_addr_in),
      .chunk_data_in   (chunk_data_in),
      .chunk_mask_in   (chunk_mask_in),
      .pixel_ready_in  (pixel_ready_in),
      .pixel_valid_out (pixel_valid_out),
      .pixel_addr_out  (pixel_addr_out),
      .pixel_data_out  (pixel_data_out),
      .frame_last_out  (frame_last_out),
      .busy_out        (busy_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      vecs++;
      if (act !== expv) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   function automatic chunk_t ramp(input logic [15:0] base);
      chunk_t c;
      for (int i = 0; i < 8; i++) c[i] = base + 16'(i);
      return c;
   endfunction

   // Downstream ready: steady high, or a coin flip every cycle.
   always @(posedge clk_in) begin
      #1;
      if (rand_rdy) pixel_ready_in = 1'($urandom_range(0, 1));
      else          pixel_ready_in = 1'b1;
   end

   // Compare process: the presented pixel must always be the model queue head.
   always @(negedge clk_in) begin
      cyc++;
      if (!rst_n_in) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", 64'(pixel_valid_out), 64'd1);
            chk("stall_addr", 64'(pixel_addr_out), 64'(prev_addr));
            chk("stall_data", 64'(pixel_data_out), 64'(prev_data));
         end
         if (exp_q.size() != 0) chk("busy_while_work", 64'(busy_out), 64'd1);
         if (pixel_valid_out) begin
            chk("spurious_pixel", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               chk("pix_addr", 64'(pixel_addr_out), 64'(exp_q[0].addr));
               chk("pix_data", 64'(pixel_data_out), 64'(exp_q[0].data));
               chk("frame_last", 64'(frame_last_out), 64'(exp_q[0].addr == ADDR_W'(LAST_PIX)));
               if (pixel_ready_in) begin
                  fired_log.push_back('{exp_q[0].addr, exp_q[0].data, cyc});
                  if (frame_last_out) last_cnt++;
                  void'(exp_q.pop_front());
               end
            end
         end else begin
            chk("frame_last_idle", 64'(frame_last_out), 64'd0);
         end
         if (chunk_valid_in && chunk_ready_out) begin
            for (int i = 0; i < 8; i++)
               if (chunk_mask_in[i]) exp_q.push_back('{{chunk_addr_in, 3'(i)}, chunk_data_in[i]});
         end
         prev_stall = pixel_valid_out && !pixel_ready_in;
         prev_addr  = pixel_addr_out;
         prev_data  = pixel_data_out;
      end
   end

   // Called and returns just after a rising edge.
   task automatic send_chunk(input logic [CHUNK_W-1:0] a, input chunk_mask_t m,
                             input chunk_t d, output int waits);
      bit got = 1'b0;
      waits = 0;
      chunk_valid_in = 1'b1;
      chunk_addr_in  = a;
      chunk_mask_in  = m;
      chunk_data_in  = d;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk_in);
         if (chunk_ready_out) begin
            got = 1'b1;
            break;
         end
         waits++;
         @(posedge clk_in);
         #1;
      end
      @(posedge clk_in);
      #1;
      chunk_valid_in = 1'b0;
      if (!got) chk("accept_timeout", 64'd0, 64'd1);
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk_in);
         #1;
         if (exp_q.size() == 0 && !busy_out) begin
            done = 1'b1;
            break;
         end
      end
      chk("drain_idle", 64'(done), 64'd1);
      @(posedge clk_in);
      #1;
   endtask

   initial begin
      int w;
      int total;
      chunk_mask_t m;
      rst_n_in       = 1'b0;
      chunk_valid_in = 1'b0;
      chunk_addr_in  = '0;
      chunk_data_in  = '0;
      chunk_mask_in  = '0;
      #1;
      chk("rst_ready", 64'(chunk_ready_out), 64'd0);
      chk("rst_valid", 64'(pixel_valid_out), 64'd0);
      chk("rst_addr", 64'(pixel_addr_out), 64'd0);
      chk("rst_data", 64'(pixel_data_out), 64'd0);
      chk("rst_last", 64'(frame_last_out), 64'd0);
      chk("rst_busy", 64'(busy_out), 64'd0);
      repeat (3) @(posedge clk_in);
      #1 rst_n_in = 1'b1;

      // Single full chunk, one-cycle latency.
      fired_log.delete();
      send_chunk(17'd5, 8'hFF, ramp(16'h1000), w);
      chk("first_accept_wait", 64'(w), 64'd0);
      chk("lat_valid", 64'(pixel_valid_out), 64'd1);
      chk("lat_addr", 64'(pixel_addr_out), 64'd40);
      chk("lat_data", 64'(pixel_data_out), 64'h1000);
      drain();
      chk("t1_count", 64'(fired_log.size()), 64'd8);
      for (int i = 0; i < fired_log.size(); i++) begin
         chk("t1_addr", 64'(fired_log[i].addr), 64'(40 + i));
         chk("t1_data", 64'(fired_log[i].data), 64'(16'h1000 + 16'(i)));
      end

      // Back-to-back chunks with no bubble at the boundary.
      fired_log.delete();
      send_chunk(17'd0, 8'hFF, ramp(16'h0100), w);
      send_chunk(17'd1, 8'hFF, ramp(16'h0200), w);
      chk("pend_full_ready", 64'(chunk_ready_out), 64'd0);
      chk("pend_full_busy", 64'(busy_out), 64'd1);
      drain();
      chk("t2_count", 64'(fired_log.size()), 64'd16);
      if (fired_log.size() == 16) begin
         chk("t2_span", 64'(fired_log[15].cyc - fired_log[0].cyc), 64'd15);
         chk("t2_addr15", 64'(fired_log[15].addr), 64'd15);
      end

      // Sparse mask and zero mask.
      fired_log.delete();
      send_chunk(17'd2, 8'b1010_0100, ramp(16'h0300), w);
      drain();
      chk("t3_count", 64'(fired_log.size()), 64'd3);
      if (fired_log.size() == 3) begin
         chk("t3_a0", 64'(fired_log[0].addr), 64'd18);
         chk("t3_a1", 64'(fired_log[1].addr), 64'd21);
         chk("t3_a2", 64'(fired_log[2].addr), 64'd23);
         chk("t3_d2", 64'(fired_log[2].data), 64'h0307);
      end
      fired_log.delete();
      send_chunk(17'd3, 8'h00, ramp(16'h0400), w);
      chk("zero_busy", 64'(busy_out), 64'd1);
      chk("zero_valid", 64'(pixel_valid_out), 64'd0);
      drain();
      chk("zero_count", 64'(fired_log.size()), 64'd0);

      // Frame end, enabled and disabled.
      last_cnt = 0;
      fired_log.delete();
      send_chunk(17'd115199, 8'hFF, ramp(16'h0500), w);
      drain();
      chk("last_cnt_ff", 64'(last_cnt), 64'd1);
      if (fired_log.size() == 8) chk("last_addr", 64'(fired_log[7].addr), 64'd921599);
      last_cnt = 0;
      send_chunk(17'd115199, 8'h7F, ramp(16'h0600), w);
      drain();
      chk("last_cnt_7f", 64'(last_cnt), 64'd0);

      // Random chunks, random gaps, random backpressure.
      rand_rdy = 1'b1;
      fired_log.delete();
      total = 0;
      for (int n = 0; n < 64; n++) begin
         chunk_t d;
         for (int i = 0; i < 8; i++) d[i] = 16'($urandom);
         m = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         total += $countones(m);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk_in);
            #1;
         end
         send_chunk(17'($urandom_range(0, 115199)), m, d, w);
      end
      drain();
      chk("rand_count", 64'(fired_log.size()), 64'(total));
      rand_rdy = 1'b0;
      @(posedge clk_in);
      #1;

      // Reset after three pixels of a chunk.
      fired_log.delete();
      send_chunk(17'd7, 8'hFF, ramp(16'h2000), w);
      for (int k = 0; k < 50 && fired_log.size() < 3; k++) begin
         @(negedge clk_in);
         #1;
      end
      chk("pre_rst_count", 64'(fired_log.size()), 64'd3);
      @(posedge clk_in);
      #1 rst_n_in = 1'b0;
      #1;
      exp_q.delete();
      chk("mid_rst_valid", 64'(pixel_valid_out), 64'd0);
      chk("mid_rst_addr", 64'(pixel_addr_out), 64'd0);
      chk("mid_rst_data", 64'(pixel_data_out), 64'd0);
      chk("mid_rst_busy", 64'(busy_out), 64'd0);
      chk("mid_rst_ready", 64'(chunk_ready_out), 64'd0);
      repeat (2) @(posedge clk_in);
      #1 rst_n_in = 1'b1;
      fired_log.delete();
      send_chunk(17'd9, 8'hFF, ramp(16'h3000), w);
      chk("post_rst_wait", 64'(w), 64'd0);
      chk("post_rst_addr", 64'(pixel_addr_out), 64'd72);
      chk("post_rst_data", 64'(pixel_data_out), 64'h3000);
      drain();
      chk("post_rst_count", 64'(fired_log.size()), 64'd8);
      if (fired_log.size() == 8) chk("post_rst_a7", 64'(fired_log[7].addr), 64'd79);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/pixel_unstacker.md
Name: pixel_unstacker

Overview:
- Read-side counterpart of the framebuffer write packer.
- Accepts 128-bit framebuffer chunks (8 x 16-bit pixels) with chunk address and per-pixel enable mask, typically from the DRAM read-return FIFO.
- Emits the enabled pixels one per cycle, lowest index first, with full pixel address, toward display/scanout or readback logic.
- Two-slot chunk buffering sustains 1 pixel/cycle across chunk boundaries.

Parameters:
- HRES, 1280, horizontal resolution in pixels.
- VRES, 720, vertical resolution in pixels.
- Derived localparams, not overridable:
  - ADDR_W = $clog2(HRES*VRES), pixel address width (20 at defaults).
  - CHUNK_W = $clog2(HRES*VRES/8), chunk address width (17 at defaults).
  - LAST_PIX = HRES*VRES-1.

Ports:
- clk_in  input  1  single clock domain.
- rst_n_in  input  1  asynchronous active-low reset.
- chunk_valid_in  input  1  upstream chunk present.
- chunk_ready_out  output  1  block can accept a chunk this cycle.
- chunk_addr_in  input  CHUNK_W  chunk address (pixel address >> 3).
- chunk_data_in  input  [7:0][15:0]  pixels; element i = pixel address {chunk_addr,i}.
- chunk_mask_in  input  8  bit i=1: emit pixel i; bit i=0: skip it.
- pixel_ready_in  input  1  downstream accepts pixel.
- pixel_valid_out  output  1  pixel presented.
- pixel_addr_out  output  ADDR_W  {active chunk addr, index}.
- pixel_data_out  output  16  pixel value.
- frame_last_out  output  1  presented pixel is LAST_PIX.
- busy_out  output  1  any chunk held (active or pending).

Behaviour:
- Clock/reset: one clock, clk_in; reset asynchronous, active-low, on rst_n_in.
- Reset (rst_n_in low, asynchronous assert):
  - active and pending slots invalid, remaining masks 0.
  - pixel_valid_out=0, frame_last_out=0, busy_out=0, chunk_ready_out=0.
  - pixel_addr_out and pixel_data_out = 0.
  - Reset mid-operation discards all buffered chunks, with no partial output afterwards.
  - First accept is possible in the first clock edge after deassertion.
- State: active slot {addr, data, remaining mask, valid}; pending slot {addr, data, mask, valid}.
- chunk_ready_out = !pending_valid (combinational from registered state; no dependence on chunk_valid_in). A transfer happens on a clock edge with chunk_valid_in && chunk_ready_out.
- Output selection:
  - idx = lowest set bit of active remaining mask (priority encoder).
  - pixel_valid_out = active_valid && remaining!=0.
  - pixel_data_out = active_data[idx].
  - pixel_addr_out = {active_addr, idx}.
  - Outputs are stable while pixel_valid_out && !pixel_ready_in.
- Pixel handshake: on pixel_valid_out && pixel_ready_in, clear remaining[idx]. If that was the last set bit, the active slot retires that edge.
- Retire/refill on the same edge, in priority order:
  1. pending valid: pending moves to active; an accepted incoming chunk enters pending.
  2. pending empty and a chunk is accepted: the chunk goes straight to active.
  3. otherwise: active becomes invalid.
- Acceptance while active valid and not retiring: the chunk goes to pending.
- Acceptance while active invalid: the chunk goes to active.
- Zero-mask chunk: accepted normally, produces no pixels, and is retired on the edge after it becomes active. One bubble cycle is permitted for this case only.
- Latency: a chunk accepted at edge N into empty active gives pixel_valid_out high in cycle N+1.
- Throughput: with pixel_ready_in held high and chunks continuously available, the first pixel of the next chunk directly follows the last pixel of the current chunk, with no bubble.
- frame_last_out = pixel_valid_out && pixel_addr_out==LAST_PIX. It is masked by the enable: if pixel 7 of the last chunk is disabled, frame_last_out does not assert.
- busy_out = active_valid || pending_valid.
- Out-of-range chunk_addr_in is not checked; it is passed through verbatim.

Decomposition:
- Shared package fb_pkg:
  - pixel_t (logic [15:0]).
  - chunk_t (logic [7:0][15:0]).
  - chunk_mask_t (logic [7:0]).
  - Width functions addr_w(HRES,VRES) and chunk_w(HRES,VRES), also for use by the write packer.
- One sub-module: pixel_prio_enc, 8-bit to lowest-set index [2:0] plus any_set; combinational.
- Slot registers and control stay in pixel_unstacker.

Test Plan:
- Single chunk, addr 5, mask 8'hFF, data element i = 16'h1000+i, ready high → 8 consecutive pixels with addr 40..47 and data 16'h1000..16'h1007. First pixel valid the cycle after accept.
- Back-to-back chunks addr 0 then 1, mask FF, continuous ready → 16 pixels on 16 consecutive cycles. chunk_ready_out drops while pending is full.
- Mask 8'b1010_0100, addr 2 → exactly 3 pixels at addr 18, 21, 23. Zero-mask chunk → no pixels, busy_out clears.
- Backpressure: pixel_ready_in toggled at random → addr/data held while stalled; no loss or duplication over 64 chunks, checked against a scoreboard.
- Chunk addr LAST_PIX>>3 (115199), mask FF → frame_last_out only with addr 921599. Same test with mask 8'h7F → frame_last_out never asserts.
- Reset asserted mid-chunk after 3 pixels → outputs zero immediately (asynchronous). After release, a new chunk addr 9 yields addr 72.. with no stale pixels.
